sram_scheduler: RTL

Central controller for the audio recorder's single SRAM port. Sequences record/play/pause/idle modes from the debounced play and record buttons and owns the read and write pointers. Serialises ADC sample writes and DAC sample reads into one memory command stream for the sram interface, replacing the shared address bus between adc and dac. Sits between adc/dac and sram on the 12 MHz clk.

---
 rtl/sram_scheduler_if.sv | 34 +++
 rtl/sram_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sram_scheduler_if.sv
// Signal bundle between the scheduler and its neighbours: buttons, adc/dac
// sample handshakes, the single SRAM command port and the status outputs.
interface sram_scheduler_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              play;
    logic              record;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mode;
    logic [ADDR_W:0]   rec_len;
    logic              full;

    modport master (
        output play, record, wr_req, wr_data, rd_req, mem_rdata,
        input  rd_data, rd_valid, mem_addr, mem_read, mem_write, mem_wdata,
               mode, rec_len, full
    );

    modport slave (
        input  play, record, wr_req, wr_data, rd_req, mem_rdata,
        output rd_data, rd_valid, mem_addr, mem_read, mem_write, mem_wdata,
               mode, rec_len, full
    );
endinterface

// File: rtl/sram_scheduler.sv
// Audio recorder SRAM controller: mode FSM from button edges, pointer ownership,
// and a single serialised read/write command stream with fixed-latency dac replies.
module sram_scheduler #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    sram_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } mode_t;

    localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};

    mode_t             state, state_nx;
    logic              play_q, record_q;
    logic              pe, re;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   rptr, rec_len;
    logic              full;
    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        vld_pipe;
    logic [1:0]        mem_pipe;
    logic [DATA_W-1:0] rd_hold;

    assign re    = bus.record & ~record_q;
    assign pe    = bus.play & ~play_q & ~re;
    assign wr_ok = bus.wr_req && (state == RECORD) && !full;
    assign rd_ok = bus.rd_req && (state == PLAY) && (rptr < rec_len);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (re)                          state_nx = RECORD;
                else if (pe && rec_len != '0)    state_nx = PLAY;
            end
            RECORD: begin
                if (re || pe || full)            state_nx = IDLE;
            end
            PLAY: begin
                if (re)                          state_nx = IDLE;
                else if (pe)                     state_nx = PAUSE;
                else if (rptr == rec_len)        state_nx = IDLE;
            end
            PAUSE: begin
                if (re)                          state_nx = IDLE;
                else if (pe)                     state_nx = PLAY;
            end
            default:                             state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            play_q    <= 1'b1;
            record_q  <= 1'b1;
            wptr      <= '0;
            rptr      <= '0;
            rec_len   <= '0;
            full      <= 1'b0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            vld_pipe  <= '0;
            mem_pipe  <= '0;
            rd_hold   <= '0;
        end else begin
            state     <= state_nx;
            play_q    <= bus.play;
            record_q  <= bus.record;
            mem_write <= wr_ok;
            mem_read  <= rd_ok;

            if (wr_ok) begin
                mem_addr  <= wptr;
                mem_wdata <= bus.wr_data;
                wptr      <= wptr + 1'b1;
                rec_len   <= rec_len + 1'b1;
                if (rec_len == LAST_WORD) full <= 1'b1;
            end else if (rd_ok) begin
                mem_addr <= rptr[ADDR_W-1:0];
                rptr     <= rptr + 1'b1;
            end

            // New take discards the old one; play from idle rewinds.
            if (state == IDLE && re) begin
                wptr    <= '0;
                rec_len <= '0;
                full    <= 1'b0;
            end
            if (state == IDLE && pe && rec_len != '0) rptr <= '0;

            // Every dac request is answered two cycles later; only some went to memory.
            vld_pipe <= {vld_pipe[0], bus.rd_req};
            mem_pipe <= {mem_pipe[0], rd_ok};

            if (vld_pipe[0] && !mem_pipe[0])     rd_hold <= '0;
            else if (vld_pipe[1] && mem_pipe[1]) rd_hold <= bus.mem_rdata;
        end
    end

    // Memory data lands in the reply cycle itself, so it is steered straight
    // through while valid and then held for the dac.
    assign bus.rd_data   = (vld_pipe[1] && mem_pipe[1]) ? bus.mem_rdata : rd_hold;
    assign bus.rd_valid  = vld_pipe[1];
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mode      = state;
    assign bus.rec_len   = rec_len;
    assign bus.full      = full;
endmodule
